pipeline_ctrl_unit: RTL and testbench
=====================================

// Module: pipeline_ctrl_unit
// PURPOSE
//  Central stall/flush sequencer for the F/D/E/M pipeline. Merges the decode data hazard, E-stage
//  branch/jump mispredict, multicycle divide occupancy, data-memory busy and EBREAK halt into one
//  prioritised set of stage stall/flush controls. Also launches the iterative divider and counts
//  its cycles, and keeps performance counters. Sits beside the stage units; every stage control input is driven from here.
// PARAMETERS
//  DIV_CYCLES   32  divider latency in cycles from div_start_o to result valid (>=2)
//  CNT_BITS     32  width of the performance counters
// PORTS
//  clk_i             in   1   clock
//  reset_i           in   1   synchronous, active-high reset
//  dataHazard_i      in   1   decode load/CSR-use hazard
//  E_mispredict_i    in   1   E-stage redirect; held stable by E while E_stall_o=1
//  E_isDIV_i         in   1   valid DIV/REM instruction in E (already gated by nop)
//  M_busy_i          in   1   data memory has not completed its access
//  E_isEBREAK_i      in   1   valid EBREAK in E
//  resume_i          in   1   debug resume pulse
//  F_stall_o         out  1   hold PC/fetch register
//  D_stall_o         out  1   hold DE register update
//  D_flush_o         out  1   squash FD register (fetch bubble)
//  E_stall_o         out  1   hold E-stage state
//  E_flush_o         out  1   squash DE register (insert NOP into E)
//  M_stall_o         out  1   hold EM register
//  div_start_o       out  1   one-cycle divider launch
//  div_valid_o       out  1   one-cycle pulse: divider result ready in E this cycle
//  halted_o          out  1   core halted on EBREAK
//  stallCount_o      out  CNT_BITS  cycles with F_stall_o=1
//  flushCount_o      out  CNT_BITS  mispredict flush events
// BEHAVIOUR
//  - States: RUN, DIV, HALT. Reset: RUN, div counter 0, both counters 0, halted_o=0.
//  - Outputs combinational from state + inputs. During reset_i: all stalls 0, D_flush_o=E_flush_o=1,
//    div_start_o=div_valid_o=0.
//  - Priority (highest first): HALT > M_busy_i > DIV > mispredict > dataHazard.
//  - HALT: F/D/E/M stall=1, no flushes. resume_i -> RUN next cycle; halted_o=1 only in HALT.
//  - M_busy_i=1 in RUN/DIV: F/D/E/M stall=1. DIV counter still decrements (divider is independent).
//    Mispredict, divider launch and EBREAK entry are deferred until M_busy_i=0.
//  - RUN, E_isEBREAK_i, !M_busy_i: -> HALT next cycle; that cycle also asserts D_flush_o/E_flush_o.
//  - RUN, E_isDIV_i, !M_busy_i: div_start_o=1, F/D/E/M stall=1, counter<=DIV_CYCLES-1, -> DIV.
//  - DIV: F/D/E/M stall=1; counter decrements each cycle; at counter==1 div_valid_o=1, E/M stall
//    drop for that cycle (E retires result), F/D stall drop, -> RUN. Total occupancy DIV_CYCLES cycles.
//  - Mispredict (RUN, no higher item): D_flush_o=1, E_flush_o=1, no stalls; flushCount_o+1.
//  - dataHazard_i (RUN, no higher item, no mispredict): F_stall_o=D_stall_o=1, E_flush_o=1 (bubble).
//    Mispredict in the same cycle wins; the hazard is discarded with the flushed instruction.
//  - DIV in E with dataHazard_i: DIV rules apply; hazard re-evaluated on exit.
//  - Counters saturate at all-ones, never wrap. reset_i mid-DIV/HALT returns to RUN immediately.
//  - E_isDIV_i must not retrigger on the div_valid_o cycle (E holds the same instruction; the
//    controller suppresses a restart when exiting DIV).
// STRUCTURE
//  - ctrl_pkg: state encoding localparams (RUN/DIV/HALT), DIV_CYCLES default, counter width.
//  - One sub-module: div_seq_counter (load/decrement/last-cycle flag), instantiated once.
//  - Priority mux and perf counters in the top module.
// TESTING
//  - Reset held 2 cycles -> stalls 0, D_flush_o=E_flush_o=1, counters 0; after release all 0.
//  - dataHazard_i=1 one cycle in RUN -> F_stall_o=D_stall_o=E_flush_o=1 that cycle only; stallCount_o=1.
//  - E_isDIV_i with DIV_CYCLES=4 -> div_start_o at t0, stalls t0..t2, div_valid_o at t3, RUN at t4; no restart.
//  - E_mispredict_i + dataHazard_i same cycle -> D_flush_o=E_flush_o=1, F_stall_o=0, flushCount_o=1.
//  - M_busy_i=1 for 3 cycles with E_mispredict_i high -> all stalls 3 cycles, flush on 4th, flushCount_o=1.
//  - E_isEBREAK_i -> halted_o next cycle, all stalls held 10 cycles; resume_i -> RUN, halted_o=0.

Source files
------------

// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: controller
// state encoding and default sizing of the divider sequence and counters.
package pipeline_ctrl_unit_pkg;

    // Controller state encoding
    localparam logic [1:0] ST_RUN_ENC  = 2'd0;
    localparam logic [1:0] ST_DIV_ENC  = 2'd1;
    localparam logic [1:0] ST_HALT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN  = ST_RUN_ENC,
        ST_DIV  = ST_DIV_ENC,
        ST_HALT = ST_HALT_ENC
    } ctrl_state_e;

    // Divider latency from launch to result valid (must be >= 2)
    localparam int DIV_CYCLES_DEF = 32;

    // Width of the performance counters
    localparam int CNT_BITS_DEF = 32;

endpackage

// File: rtl/pipeline_ctrl_unit_div_seq_counter.sv
// Divider occupancy counter: loaded when the divider launches, counts down
// once per enabled cycle and flags the cycle in which the result is ready.
module pipeline_ctrl_unit_div_seq_counter #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority over decrement; never decrement below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Central stall/flush sequencer for the F/D/E/M pipeline. Resolves data
// hazards, E-stage redirects, divider occupancy, data-memory busy and the
// EBREAK halt into one prioritised set of stage controls, and keeps
// saturating stall/flush performance counters.
//
// Priority, highest first: HALT > M_busy_i > DIV > mispredict > dataHazard.
// Stage controls are combinational from the registered state and inputs.
module pipeline_ctrl_unit
    import pipeline_ctrl_unit_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_BITS   = CNT_BITS_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                dataHazard_i,
    input  logic                E_mispredict_i,
    input  logic                E_isDIV_i,
    input  logic                M_busy_i,
    input  logic                E_isEBREAK_i,
    input  logic                resume_i,
    output logic                F_stall_o,
    output logic                D_stall_o,
    output logic                D_flush_o,
    output logic                E_stall_o,
    output logic                E_flush_o,
    output logic                M_stall_o,
    output logic                div_start_o,
    output logic                div_valid_o,
    output logic                halted_o,
    output logic [CNT_BITS-1:0] stallCount_o,
    output logic [CNT_BITS-1:0] flushCount_o
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_last;
    logic flush_evt;

    logic [CNT_BITS-1:0] stall_cnt_q;
    logic [CNT_BITS-1:0] stall_cnt_d;
    logic [CNT_BITS-1:0] flush_cnt_q;
    logic [CNT_BITS-1:0] flush_cnt_d;

    pipeline_ctrl_unit_div_seq_counter #(
        .W (CW)
    ) u_div_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (DIV_LOAD),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

    // Priority mux: next state and all stage controls
    always_comb begin
        state_d     = state_q;
        F_stall_o   = 1'b0;
        D_stall_o   = 1'b0;
        D_flush_o   = 1'b0;
        E_stall_o   = 1'b0;
        E_flush_o   = 1'b0;
        M_stall_o   = 1'b0;
        div_start_o = 1'b0;
        div_valid_o = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        flush_evt   = 1'b0;

        if (reset_i) begin
            // Squash both front-end registers while held in reset
            D_flush_o = 1'b1;
            E_flush_o = 1'b1;
        end else begin
            case (state_q)
                ST_HALT: begin
                    F_stall_o = 1'b1;
                    D_stall_o = 1'b1;
                    E_stall_o = 1'b1;
                    M_stall_o = 1'b1;
                    if (resume_i) begin
                        state_d = ST_RUN;
                    end
                end

                ST_DIV: begin
                    if (M_busy_i) begin
                        // Divider keeps running, but the result cannot
                        // retire while M is frozen: hold at the last cycle.
                        F_stall_o = 1'b1;
                        D_stall_o = 1'b1;
                        E_stall_o = 1'b1;
                        M_stall_o = 1'b1;
                        cnt_dec   = !cnt_last;
                    end else if (cnt_last) begin
                        // Result retires in E; the DIV in E is consumed so
                        // no relaunch is possible from this cycle.
                        div_valid_o = 1'b1;
                        cnt_dec     = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        F_stall_o = 1'b1;
                        D_stall_o = 1'b1;
                        E_stall_o = 1'b1;
                        M_stall_o = 1'b1;
                        cnt_dec   = 1'b1;
                    end
                end

                default: begin
                    if (M_busy_i) begin
                        F_stall_o = 1'b1;
                        D_stall_o = 1'b1;
                        E_stall_o = 1'b1;
                        M_stall_o = 1'b1;
                    end else if (E_isEBREAK_i) begin
                        D_flush_o = 1'b1;
                        E_flush_o = 1'b1;
                        state_d   = ST_HALT;
                    end else if (E_isDIV_i) begin
                        F_stall_o   = 1'b1;
                        D_stall_o   = 1'b1;
                        E_stall_o   = 1'b1;
                        M_stall_o   = 1'b1;
                        div_start_o = 1'b1;
                        cnt_load    = 1'b1;
                        state_d     = ST_DIV;
                    end else if (E_mispredict_i) begin
                        // Redirect wins; any decode hazard dies with the
                        // squashed instruction.
                        D_flush_o = 1'b1;
                        E_flush_o = 1'b1;
                        flush_evt = 1'b1;
                    end else if (dataHazard_i) begin
                        F_stall_o = 1'b1;
                        D_stall_o = 1'b1;
                        E_flush_o = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating performance counter updates
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (F_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
        end
        if (flush_evt && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_BITS'(1);
        end
    end

    // Controller state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted_o     = (state_q == ST_HALT) && !reset_i;
    assign stallCount_o = stall_cnt_q;
    assign flushCount_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Bench for pipeline_ctrl_unit: directed vectors, a priority-rule model
// checked every cycle, and hand-computed literal expectations.
module tb_pipeline_ctrl_unit;

    localparam int DIV_CYCLES = 4;
    localparam int CNT_BITS   = 4;
    localparam int CNT_MAX    = (1 << CNT_BITS) - 1;

    // Control vector order: F_st D_st D_fl E_st E_fl M_st start valid halted
    localparam logic [8:0] V_IDLE  = 9'b000000000;
    localparam logic [8:0] V_FLUSH = 9'b001010000;
    localparam logic [8:0] V_HAZ   = 9'b110010000;
    localparam logic [8:0] V_ALLST = 9'b110101000;
    localparam logic [8:0] V_START = 9'b110101100;
    localparam logic [8:0] V_VALID = 9'b000000010;
    localparam logic [8:0] V_HALT  = 9'b110101001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_i;
    logic                dataHazard_i;
    logic                E_mispredict_i;
    logic                E_isDIV_i;
    logic                M_busy_i;
    logic                E_isEBREAK_i;
    logic                resume_i;
    logic                F_stall_o;
    logic                D_stall_o;
    logic                D_flush_o;
    logic                E_stall_o;
    logic                E_flush_o;
    logic                M_stall_o;
    logic                div_start_o;
    logic                div_valid_o;
    logic                halted_o;
    logic [CNT_BITS-1:0] stallCount_o;
    logic [CNT_BITS-1:0] flushCount_o;

    pipeline_ctrl_unit #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_BITS   (CNT_BITS)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .dataHazard_i   (dataHazard_i),
        .E_mispredict_i (E_mispredict_i),
        .E_isDIV_i      (E_isDIV_i),
        .M_busy_i       (M_busy_i),
        .E_isEBREAK_i   (E_isEBREAK_i),
        .resume_i       (resume_i),
        .F_stall_o      (F_stall_o),
        .D_stall_o      (D_stall_o),
        .D_flush_o      (D_flush_o),
        .E_stall_o      (E_stall_o),
        .E_flush_o      (E_flush_o),
        .M_stall_o      (M_stall_o),
        .div_start_o    (div_start_o),
        .div_valid_o    (div_valid_o),
        .halted_o       (halted_o),
        .stallCount_o   (stallCount_o),
        .flushCount_o   (flushCount_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    function automatic logic [8:0] ctl_vec();
        return {F_stall_o, D_stall_o, D_flush_o, E_stall_o, E_flush_o,
                M_stall_o, div_start_o, div_valid_o, halted_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit hz, input bit mis, input bit dv,
                         input bit busy, input bit eb, input bit res);
        dataHazard_i   = hz;
        E_mispredict_i = mis;
        E_isDIV_i      = dv;
        M_busy_i       = busy;
        E_isEBREAK_i   = eb;
        resume_i       = res;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [8:0] exp);
        @(negedge clk);
        chk(name, {23'd0, ctl_vec()}, {23'd0, exp});
    endtask

    task automatic lit_cnt(input string name, input int exp_stall, input int exp_flush);
        @(negedge clk);
        chk({name, "_stallcnt"}, {28'd0, stallCount_o}, exp_stall);
        chk({name, "_flushcnt"}, {28'd0, flushCount_o}, exp_flush);
    endtask

    // ---------------- reference model ----------------
    // halted flag, cycles of divider occupancy still to come, counters
    bit         m_halt     = 1'b0;
    int         m_div_left = 0;
    int         m_stalls   = 0;
    int         m_flushes  = 0;
    logic [8:0] exp_v;

    // Compare DUT against the priority rules, then advance the model
    always @(negedge clk) begin
        if (check_en) begin
            exp_v = V_IDLE;
            chk("model_stallcnt", {28'd0, stallCount_o}, m_stalls);
            chk("model_flushcnt", {28'd0, flushCount_o}, m_flushes);
            if (reset_i) begin
                exp_v      = V_FLUSH;
                m_halt     = 1'b0;
                m_div_left = 0;
                m_stalls   = 0;
                m_flushes  = 0;
            end else begin
                if (m_halt) begin
                    exp_v = V_HALT;
                    if (resume_i) m_halt = 1'b0;
                end else if (M_busy_i) begin
                    exp_v = V_ALLST;
                    if (m_div_left > 1) m_div_left--;
                end else if (m_div_left == 1) begin
                    exp_v      = V_VALID;
                    m_div_left = 0;
                end else if (m_div_left > 1) begin
                    exp_v = V_ALLST;
                    m_div_left--;
                end else if (E_isEBREAK_i) begin
                    exp_v  = V_FLUSH;
                    m_halt = 1'b1;
                end else if (E_isDIV_i) begin
                    exp_v      = V_START;
                    m_div_left = DIV_CYCLES - 1;
                end else if (E_mispredict_i) begin
                    exp_v = V_FLUSH;
                    if (m_flushes < CNT_MAX) m_flushes++;
                end else if (dataHazard_i) begin
                    exp_v = V_HAZ;
                end
                if (exp_v[8] && m_stalls < CNT_MAX) m_stalls++;
            end
            chk("model_ctl", {23'd0, ctl_vec()}, {23'd0, exp_v});
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check_en = 1'b1;
        lit("reset_ctl", V_FLUSH);
        lit_cnt("reset", 0, 0);
        cyc();
        reset_i = 1'b0;
        lit("post_reset_ctl", V_IDLE);
        cyc();

        // Single-cycle decode hazard
        drive(1, 0, 0, 0, 0, 0);
        lit("hazard_ctl", V_HAZ);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        lit("hazard_after_ctl", V_IDLE);
        lit_cnt("hazard", 1, 0);
        cyc();

        // Divide: launch, two stall cycles, result, then free
        drive(0, 0, 1, 0, 0, 0);
        lit("div_t0", V_START);
        cyc();
        lit("div_t1", V_ALLST);
        cyc();
        lit("div_t2", V_ALLST);
        cyc();
        lit("div_t3", V_VALID);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        lit("div_t4", V_IDLE);
        lit_cnt("div", 4, 0);
        cyc();

        // Mispredict beats a simultaneous hazard
        drive(1, 1, 0, 0, 0, 0);
        lit("mis_haz_ctl", V_FLUSH);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        lit_cnt("mis_haz", 4, 1);
        cyc();

        // Memory busy defers a pending mispredict
        drive(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            lit("busy_mis_stall", V_ALLST);
            cyc();
        end
        drive(0, 1, 0, 0, 0, 0);
        lit("busy_mis_flush", V_FLUSH);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        lit_cnt("busy_mis", 7, 2);
        cyc();

        // Flush counter saturates at all-ones
        for (int i = 0; i < 14; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0);
        lit_cnt("flush_sat", 7, CNT_MAX);
        cyc();

        // EBREAK: flush, then halted with all stalls for 10 cycles
        drive(0, 0, 0, 0, 1, 0);
        lit("ebreak_ctl", V_FLUSH);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            lit("halt_ctl", V_HALT);
            cyc();
        end
        drive(0, 0, 0, 0, 0, 1);
        lit("resume_ctl", V_HALT);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        lit("after_resume_ctl", V_IDLE);
        lit_cnt("stall_sat", CNT_MAX, CNT_MAX);
        cyc();

        // Divide with a hazard and memory busy inside the occupancy window
        drive(1, 0, 1, 0, 0, 0);
        lit("divhz_t0", V_START);
        cyc();
        drive(1, 0, 1, 1, 0, 0);
        lit("divhz_t1_busy", V_ALLST);
        cyc();
        drive(1, 0, 1, 0, 0, 0);
        lit("divhz_t2", V_ALLST);
        cyc();
        lit("divhz_t3", V_VALID);
        cyc();
        drive(1, 0, 0, 0, 0, 0);
        lit("divhz_t4_hazard", V_HAZ);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        cyc();

        // Reset in the middle of a divide
        drive(0, 0, 1, 0, 0, 0);
        cyc();
        lit("div_mid", V_ALLST);
        reset_i = 1'b1;
        lit("div_reset_ctl", V_FLUSH);
        cyc();
        reset_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        lit("div_reset_after", V_IDLE);
        lit_cnt("div_reset", 0, 0);
        cyc();

        // Reset while halted
        drive(0, 0, 0, 0, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        lit("halt_mid", V_HALT);
        reset_i = 1'b1;
        lit("halt_reset_ctl", V_FLUSH);
        cyc();
        reset_i = 1'b0;
        lit("halt_reset_after", V_IDLE);
        cyc();
        cyc();

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
